// File: rtl/swc_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM state encoding
// and the default debounce length (10 ms at 125 MHz).
package swc_pkg;

   // Bit 1 of the encoding is the debounced level in every state.
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b11,
      WAIT_LO   = 2'b10
   } swc_state_e;

   localparam int SWC_DEBOUNCE_CYCLES_DEF = 1_250_000;

endpackage

// File: rtl/swc_debounce_cell.sv
// One switch channel: 2-FF synchronizer, counter-based debounce FSM and optional
// rise/fall pulses (built only when SWC_EDGE_PULSE_EN is defined).
module swc_debounce_cell
   import swc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   swc_state_e       r_state;
   swc_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_state <= STABLE_LO;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         STABLE_LO: begin
            if (r_s2) begin
               w_state_nxt = WAIT_HI;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_HI: begin
            if (!r_s2) begin
               w_state_nxt = STABLE_LO;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_HI;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!r_s2) begin
               w_state_nxt = WAIT_LO;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_LO: begin
            if (r_s2) begin
               w_state_nxt = STABLE_HI;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_LO;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // The state register already holds the clean level, so no separate output flop.
   assign o_level = r_state[1];

`ifdef SWC_EDGE_PULSE_EN
   logic r_rise;
   logic r_fall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= (r_state == WAIT_HI) && (w_state_nxt == STABLE_HI);
         r_fall <= (r_state == WAIT_LO) && (w_state_nxt == STABLE_LO);
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// DIP switch conditioner between board pins and the game's SWITCHES input.
// Edge pulses are present only when SWC_EDGE_PULSE_EN is defined; otherwise tied low.
module switch_debouncer
   import swc_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES_DEF
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] SWITCHES_RAW,
   output logic [WIDTH-1:0] SWITCHES,
   output logic [WIDTH-1:0] SW_RISE,
   output logic [WIDTH-1:0] SW_FALL
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      swc_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .i_clk   (CLOCK),
         .i_rst   (RESET),
         .i_raw   (SWITCHES_RAW[gi]),
         .o_level (SWITCHES[gi]),
         .o_rise  (SW_RISE[gi]),
         .o_fall  (SW_FALL[gi])
      );
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with WIDTH=4, DEBOUNCE_CYCLES=4.
// Pulse expectations are masked to zero unless SWC_EDGE_PULSE_EN is defined.
module tb_switch_debouncer;

   localparam int WIDTH = 4;
   localparam int DEB   = 4;

`ifdef SWC_EDGE_PULSE_EN
   localparam logic [3:0] PULSE_MASK = 4'hF;
`else
   localparam logic [3:0] PULSE_MASK = 4'h0;
`endif

   typedef struct packed {
      logic       rst;
      logic [3:0] raw;
      logic [3:0] sw;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   typedef struct packed {
      logic [3:0] sw;
      logic [3:0] rise;
      logic [3:0] fall;
   } exp_t;

   logic             CLOCK = 1'b0;
   logic             RESET = 1'b1;
   logic [WIDTH-1:0] SWITCHES_RAW = '0;
   logic [WIDTH-1:0] SWITCHES;
   logic [WIDTH-1:0] SW_RISE;
   logic [WIDTH-1:0] SW_FALL;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 CLOCK = ~CLOCK;

   switch_debouncer #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .SWITCHES_RAW (SWITCHES_RAW),
      .SWITCHES     (SWITCHES),
      .SW_RISE      (SW_RISE),
      .SW_FALL      (SW_FALL)
   );

   task automatic add(input int n, input logic rst, input logic [3:0] raw,
                      input logic [3:0] sw, input logic [3:0] rise, input logic [3:0] fall);
      vec_t v;
      v.rst  = rst;
      v.raw  = raw;
      v.sw   = sw;
      v.rise = rise;
      v.fall = fall;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge, then check.
   task automatic step(input string tag, input logic rst, input logic [3:0] raw,
                       input logic [3:0] sw, input logic [3:0] rise, input logic [3:0] fall);
      exp_t e;
      RESET        = rst;
      SWITCHES_RAW = raw;
      e.sw   = sw;
      e.rise = rise & PULSE_MASK;
      e.fall = fall & PULSE_MASK;
      sb.push_back(e);
      @(posedge CLOCK);
      #1;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         if ({SWITCHES, SW_RISE, SW_FALL} !== {e.sw, e.rise, e.fall}) begin
            n_fail++;
            $display("FAIL %s: got sw=%b rise=%b fall=%b, want sw=%b rise=%b fall=%b",
                     tag, SWITCHES, SW_RISE, SW_FALL, e.sw, e.rise, e.fall);
         end
      end
   endtask

   initial begin
      // reset with all switches high, then idle
      add(3, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      add(2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // clean press on channel 0: change at vector 5, update at vector 11
      add(6, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      add(2, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      // release channel 0
      add(6, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // simultaneous press and release on channels 1 and 3
      add(6, 1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
      add(1, 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
      add(6, 1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1010);
      add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].raw,
              vecs[i].sw, vecs[i].rise, vecs[i].fall);

      // short bounce on channel 1: 3 cycles high is rejected
      for (int c = 0; c < 10; c++)
         step($sformatf("bounce3_c%0d", c), 1'b0, (c < 3) ? 4'b0010 : 4'b0000,
              4'b0000, 4'b0000, 4'b0000);

      // bounce on the final count cycle, then held high: rise 6 edges after re-high (c=5)
      for (int c = 0; c < 13; c++)
         step($sformatf("late_bounce_c%0d", c), 1'b0, (c == 4) ? 4'b0000 : 4'b0010,
              (c >= 11) ? 4'b0010 : 4'b0000, (c == 11) ? 4'b0010 : 4'b0000, 4'b0000);

      for (int c = 0; c < 8; c++)
         step($sformatf("late_release_c%0d", c), 1'b0, 4'b0000,
              (c >= 6) ? 4'b0000 : 4'b0010, 4'b0000, (c == 6) ? 4'b0010 : 4'b0000);

      // channel 2 pressed, reset lands two edges into WAIT_HI
      for (int c = 0; c < 4; c++)
         step($sformatf("midwait_pre_c%0d", c), 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      for (int c = 0; c < 2; c++)
         step($sformatf("midwait_rst_c%0d", c), 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      for (int d = 0; d < 8; d++)
         step($sformatf("midwait_post_d%0d", d), 1'b0, 4'b0100,
              (d >= 6) ? 4'b0100 : 4'b0000, (d == 6) ? 4'b0100 : 4'b0000, 4'b0000);

      // reset clears a settled level; a switch held through reset debounces again
      step("held_rst", 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      for (int d = 0; d < 8; d++)
         step($sformatf("held_post_d%0d", d), 1'b0, 4'b0100,
              (d >= 6) ? 4'b0100 : 4'b0000, (d == 6) ? 4'b0100 : 4'b0000, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
